// File: rtl/imem_boot_loader_if.sv
// Byte stream and instruction-memory write bundle
// for the boot loader.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output mem_we,
    output mem_waddr,
    output mem_wdata
  );

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Byte-serial boot loader: header, LE words, NOP
// fill, then core reset release.
module imem_boot_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  imem_boot_loader_if.slave   bus,
  output logic                core_rst_n,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_N =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_N =
    (ADDR_W+1)'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [7:0]        nlo_q, nlo_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [ADDR_W-1:0] fidx_q, fidx_d;
  logic [23:0]       shf_q, shf_d;

  logic              rdy_q, rdy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              crst_q, crst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [15:0]       hdr_n;
  logic              hdr_ok;
  logic              last_word;

  assign xfer   = bus.rx_valid & rdy_q;
  assign hdr_n  = {bus.rx_data, nlo_q};
  assign hdr_ok = (hdr_n != 16'd0) &&
                  (hdr_n <= 16'(DEPTH));
  assign last_word =
    ({1'b0, widx_q} == (n_q - ONE_N));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    nlo_d   = nlo_q;
    n_d     = n_q;
    widx_d  = widx_q;
    fidx_d  = fidx_q;
    shf_d   = shf_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          bcnt_d  = 2'd0;
          shf_d   = 24'd0;
          widx_d  = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (bcnt_q == 2'd0) begin
            nlo_d  = bus.rx_data;
            bcnt_d = 2'd1;
          end else begin
            bcnt_d = 2'd0;
            if (hdr_ok) begin
              n_d     = hdr_n[ADDR_W:0];
              widx_d  = '0;
              state_d = S_DATA;
            end else begin
              state_d = S_ERR;
            end
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q != 2'd3) begin
            shf_d = {bus.rx_data, shf_q[23:8]};
          end else begin
            we_d    = 1'b1;
            waddr_d = widx_q;
            wdata_d = {bus.rx_data, shf_q};
            widx_d  = widx_q + 1'b1;
            if (last_word) begin
              if (n_q == DEPTH_N) begin
                state_d = S_DONE;
              end else begin
                fidx_d  = n_q[ADDR_W-1:0];
                state_d = S_FILL;
              end
            end
          end
        end
      end
      S_FILL: begin
        we_d    = 1'b1;
        waddr_d = fidx_q;
        wdata_d = NOP_WORD;
        fidx_d  = fidx_q + 1'b1;
        if (fidx_q == '1) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The final write still occupies the cycle after
  // DONE is entered, so release is held back by it.
  always_comb begin
    rdy_d  = (state_d == S_HDR) ||
             (state_d == S_DATA);
    done_d = (state_d == S_DONE) && !we_d;
    crst_d = done_d;
    err_d  = (state_d == S_ERR);
    busy_d = rdy_d || (state_d == S_FILL) || we_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bcnt_q  <= 2'd0;
      nlo_q   <= 8'd0;
      n_q     <= '0;
      widx_q  <= '0;
      fidx_q  <= '0;
      shf_q   <= 24'd0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
      crst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      nlo_q   <= nlo_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      fidx_q  <= fidx_d;
      shf_q   <= shf_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.rx_ready  = rdy_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign core_rst_n    = crst_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: loads, errors,
// gaps, mid-load reset and start handling.
module tb_imem_boot_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic core_rst_n;
  logic busy;
  logic done;
  logic err;

  imem_boot_loader_if #(.ADDR_W(8)) bus();

  imem_boot_loader #(
    .ADDR_W  (8),
    .NOP_WORD(NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int tests = 0;
  int fails = 0;

  int          cyc = 0;
  int          wr_cnt = 0;
  int          last_we_cyc = 0;
  int          done_rise_cyc = 0;
  int          viol = 0;
  logic        done_prev = 1'b0;
  logic [7:0]  wa [0:2047];
  logic [31:0] wd [0:2047];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    done_prev <= done;
    if (bus.mem_we === 1'b1) begin
      if (wr_cnt < 2048) begin
        wa[wr_cnt] <= bus.mem_waddr;
        wd[wr_cnt] <= bus.mem_wdata;
      end
      wr_cnt <= wr_cnt + 1;
      last_we_cyc <= cyc + 1;
    end
    if (done === 1'b1 && done_prev !== 1'b1)
      done_rise_cyc <= cyc + 1;
    if ((bus.rx_ready === 1'b1 && busy !== 1'b1) ||
        (bus.mem_we === 1'b1 && err === 1'b1))
      viol <= viol + 1;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL send_byte: rx_ready=%b needed 1",
               bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_end();
    int n = 0;
    while (done !== 1'b1 && err !== 1'b1 &&
           n < 5000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 5000) begin
      fails++;
      $display("FAIL wait_end: done=%b err=%b need end",
               done, err);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests += 8;
    if (bus.rx_ready !== 1'b0) begin fails++;
      $display("FAIL rst rx_ready: %b need 0",
               bus.rx_ready); end
    if (bus.mem_we !== 1'b0) begin fails++;
      $display("FAIL rst mem_we: %b need 0",
               bus.mem_we); end
    if (bus.mem_waddr !== 8'h00) begin fails++;
      $display("FAIL rst mem_waddr: %h need 00",
               bus.mem_waddr); end
    if (bus.mem_wdata !== 32'h0) begin fails++;
      $display("FAIL rst mem_wdata: %h need 0",
               bus.mem_wdata); end
    if (core_rst_n !== 1'b0) begin fails++;
      $display("FAIL rst core_rst_n: %b need 0",
               core_rst_n); end
    if (busy !== 1'b0) begin fails++;
      $display("FAIL rst busy: %b need 0", busy); end
    if (done !== 1'b0) begin fails++;
      $display("FAIL rst done: %b need 0", done); end
    if (err !== 1'b0) begin fails++;
      $display("FAIL rst err: %b need 0", err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.rx_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle: rdy=%b busy=%b need 0 0",
               bus.rx_ready, busy);
    end
  endtask

  task automatic test_two_word(input int gap);
    int base;
    int v0;
    int bad = 0;
    logic [7:0] img [0:9];
    img = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h00,
            8'h10, 8'h93, 8'h02, 8'h50, 8'h00};
    @(negedge clk);
    base = wr_cnt;
    v0   = viol;
    pulse_start();
    for (int i = 0; i < 10; i++)
      send_byte(img[i], gap);
    wait_end();
    tests++;
    if (wr_cnt - base !== 256) begin fails++;
      $display("FAIL img gap%0d count: %0d need 256",
               gap, wr_cnt - base); end
    tests++;
    if (wa[base] !== 8'd0 ||
        wd[base] !== 32'h1000_0113) begin fails++;
      $display("FAIL img gap%0d w0: %h@%h need 10000113@00",
               gap, wd[base], wa[base]); end
    tests++;
    if (wa[base+1] !== 8'd1 ||
        wd[base+1] !== 32'h0050_0293) begin fails++;
      $display("FAIL img gap%0d w1: %h@%h need 00500293@01",
               gap, wd[base+1], wa[base+1]); end
    for (int i = 2; i < 256; i++)
      if (wa[base+i] !== 8'(i) || wd[base+i] !== NOP)
        bad++;
    tests++;
    if (bad != 0) begin fails++;
      $display("FAIL img gap%0d nop fill: %0d bad need 0",
               gap, bad); end
    tests++;
    if (done_rise_cyc !== last_we_cyc + 1) begin
      fails++;
      $display("FAIL img gap%0d done timing: %0d need %0d",
               gap, done_rise_cyc, last_we_cyc + 1); end
    tests++;
    if (core_rst_n !== 1'b1 || done !== 1'b1 ||
        busy !== 1'b0) begin fails++;
      $display("FAIL img gap%0d status: crst=%b done=%b busy=%b need 1 1 0",
               gap, core_rst_n, done, busy); end
    tests++;
    if (viol !== v0) begin fails++;
      $display("FAIL img gap%0d rx_ready/we: %0d bad need 0",
               gap, viol - v0); end
  endtask

  function automatic logic [31:0] full_word(int i);
    logic [7:0] k;
    k = 8'(i);
    return {k, ~k, 8'hC3, k ^ 8'h5A};
  endfunction

  task automatic test_full_depth();
    int base;
    int bad = 0;
    logic [31:0] w;
    @(negedge clk);
    base = wr_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    for (int i = 0; i < 256; i++) begin
      w = full_word(i);
      send_byte(w[7:0], 0);
      send_byte(w[15:8], 0);
      send_byte(w[23:16], 0);
      send_byte(w[31:24], 0);
    end
    wait_end();
    tests++;
    if (wr_cnt - base !== 256) begin fails++;
      $display("FAIL full count: %0d need 256",
               wr_cnt - base); end
    for (int i = 0; i < 256; i++)
      if (wa[base+i] !== 8'(i) ||
          wd[base+i] !== full_word(i))
        bad++;
    tests++;
    if (bad != 0) begin fails++;
      $display("FAIL full data: %0d bad need 0", bad);
    end
    tests++;
    if (done_rise_cyc !== last_we_cyc + 1) begin
      fails++;
      $display("FAIL full done timing: %0d need %0d",
               done_rise_cyc, last_we_cyc + 1); end
  endtask

  task automatic test_header_err();
    int base;
    int bad = 0;
    @(negedge clk);
    base = wr_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    tests++;
    if (err !== 1'b1 || core_rst_n !== 1'b0 ||
        bus.rx_ready !== 1'b0) begin fails++;
      $display("FAIL err N=0: err=%b crst=%b rdy=%b need 1 0 0",
               err, core_rst_n, bus.rx_ready); end
    tests++;
    if (wr_cnt !== base) begin fails++;
      $display("FAIL err N=0 writes: %0d need 0",
               wr_cnt - base); end
    pulse_start();
    tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin fails++;
      $display("FAIL err clear: err=%b busy=%b need 0 1",
               err, busy); end
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    tests++;
    if (err !== 1'b1 || wr_cnt !== base) begin
      fails++;
      $display("FAIL err N=257: err=%b writes=%0d need 1 0",
               err, wr_cnt - base); end
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    wait_end();
    tests++;
    if (wr_cnt - base !== 256 ||
        wd[base] !== 32'h1234_5678 ||
        wa[base] !== 8'd0) begin fails++;
      $display("FAIL err reload: n=%0d w0=%h need 256 12345678",
               wr_cnt - base, wd[base]); end
    for (int i = 1; i < 256; i++)
      if (wa[base+i] !== 8'(i) || wd[base+i] !== NOP)
        bad++;
    tests++;
    if (bad != 0 || done !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL err reload fill: bad=%0d done=%b err=%b need 0 1 0",
               bad, done, err); end
  endtask

  task automatic test_mid_reset();
    int base;
    @(negedge clk);
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.rx_ready !== 1'b0 || bus.mem_we !== 1'b0 ||
        bus.mem_waddr !== 8'h0 || bus.mem_wdata !== 32'h0 ||
        core_rst_n !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0) begin fails++;
      $display("FAIL abort: rdy=%b we=%b a=%h d=%h crst=%b busy=%b done=%b err=%b need all 0",
               bus.rx_ready, bus.mem_we, bus.mem_waddr,
               bus.mem_wdata, core_rst_n, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = wr_cnt;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEF, 0);
    send_byte(8'h00, 0);
    send_byte(8'hC0, 0);
    send_byte(8'h00, 0);
    wait_end();
    tests++;
    if (wa[base] !== 8'd0 ||
        wd[base] !== 32'h00C0_00EF) begin fails++;
      $display("FAIL abort reload w0: %h@%h need 00c000ef@00",
               wd[base], wa[base]); end
    tests++;
    if (wr_cnt - base !== 256 || core_rst_n !== 1'b1)
    begin fails++;
      $display("FAIL abort reload: n=%0d crst=%b need 256 1",
               wr_cnt - base, core_rst_n); end
  endtask

  task automatic test_start_ignored();
    int base;
    @(negedge clk);
    base = wr_cnt;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    pulse_start();
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    wait_end();
    tests++;
    if (wr_cnt - base !== 256 ||
        wd[base] !== 32'hDDCC_BBAA) begin fails++;
      $display("FAIL start mid-data: n=%0d w0=%h need 256 ddccbbaa",
               wr_cnt - base, wd[base]); end
    tests++;
    if (done !== 1'b1 || core_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL pre-restart: done=%b crst=%b need 1 1",
               done, core_rst_n); end
    @(negedge clk);
    pulse_start();
    tests++;
    if (core_rst_n !== 1'b0 || done !== 1'b0 ||
        busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL restart: crst=%b done=%b busy=%b rdy=%b need 0 0 1 1",
               core_rst_n, done, busy, bus.rx_ready); end
  endtask

  initial begin
    test_reset();
    test_two_word(0);
    test_full_depth();
    test_header_err();
    test_two_word(2);
    test_mid_reset();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
